// File: rtl/riscv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared definitions for the RV32I multi-cycle controller: sequencer states,
// opcode/func7 constants, the control-word field encodings consumed by the
// datapath, and the packed control word itself.
// -----------------------------------------------------------------------------
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    // Major opcodes accepted by this core.
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU operation encodings.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLTU = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    // Branch-unit operations: conditional branches carry func3 in the low bits.
    localparam logic [4:0] BU_NONE       = 5'b00000;
    localparam logic [4:0] BU_JUMP       = 5'b10000;
    localparam logic [1:0] BU_BRANCH_PFX = 2'b01;

    // Immediate formats.
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b101;
    localparam logic [2:0] IMM_J = 3'b110;

    // Register write-back source.
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef struct packed {
        logic [3:0] ALUOp;
        logic       ALUAsrc;
        logic       ALUBsrc;
        logic [2:0] Immsrc;
        logic [4:0] BUOp;
        logic       DmWr;
        logic [2:0] DmCtrl;
        logic [1:0] RuDataWrsrc;
        logic       RuWr;
    } ctrl_word_t;

    // Base ALU operation selected by func3 (shared by R-type and I-ALU).
    function automatic logic [3:0] alu_op_base(input logic [2:0] func3);
        logic [3:0] op;
        case (func3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// -----------------------------------------------------------------------------
// ctrl_decoder
// Purely combinational instruction decoder. Maps an RV32I instruction word to
// the datapath control word and flags instructions this core does not accept.
//   instr_i    [31:0]  instruction word (from the IR)
//   ctrl_o             decoded control word; unused fields are 0
//   illegal_o          1 when the instruction is not supported
// -----------------------------------------------------------------------------
module ctrl_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_word_t  ctrl_o,
    output logic        illegal_o
);

    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;

    assign opcode = instr_i[6:0];
    assign func3  = instr_i[14:12];
    assign func7  = instr_i[31:25];

    // Register and immediate fields are routed to the datapath elsewhere.
    logic unused_fields;
    assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a value held over, which would otherwise infer a latch.
        ctrl_o    = '0;
        illegal_o = 1'b0;

        case (opcode)
            OPC_R: begin
                ctrl_o.RuWr        = 1'b1;
                ctrl_o.RuDataWrsrc = WB_ALU;
                if (func7 == F7_BASE) begin
                    ctrl_o.ALUOp = alu_op_base(func3);
                end else if (func7 == F7_ALT && func3 == 3'b000) begin
                    ctrl_o.ALUOp = ALU_SUB;
                end else if (func7 == F7_ALT && func3 == 3'b101) begin
                    ctrl_o.ALUOp = ALU_SRA;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OPC_I_ALU: begin
                // func7 is deliberately ignored: shift-immediates all map to
                // the base operation.
                ctrl_o.ALUOp   = alu_op_base(func3);
                ctrl_o.ALUBsrc = 1'b1;
                ctrl_o.Immsrc  = IMM_I;
                ctrl_o.RuWr    = 1'b1;
            end
            OPC_LOAD: begin
                ctrl_o.ALUOp       = ALU_ADD;
                ctrl_o.ALUBsrc     = 1'b1;
                ctrl_o.Immsrc      = IMM_I;
                ctrl_o.RuDataWrsrc = WB_MEM;
                ctrl_o.DmCtrl      = func3;
                ctrl_o.RuWr        = 1'b1;
            end
            OPC_STORE: begin
                ctrl_o.ALUOp   = ALU_ADD;
                ctrl_o.ALUBsrc = 1'b1;
                ctrl_o.Immsrc  = IMM_S;
                ctrl_o.DmWr    = 1'b1;
                ctrl_o.DmCtrl  = func3;
            end
            OPC_BRANCH: begin
                ctrl_o.ALUAsrc = 1'b1;
                ctrl_o.ALUBsrc = 1'b1;
                ctrl_o.Immsrc  = IMM_B;
                ctrl_o.BUOp    = {BU_BRANCH_PFX, func3};
                illegal_o      = (func3 == 3'b010) || (func3 == 3'b011);
            end
            OPC_JAL: begin
                ctrl_o.ALUAsrc     = 1'b1;
                ctrl_o.ALUBsrc     = 1'b1;
                ctrl_o.Immsrc      = IMM_J;
                ctrl_o.BUOp        = BU_JUMP;
                ctrl_o.RuDataWrsrc = WB_PC4;
                ctrl_o.RuWr        = 1'b1;
            end
            OPC_JALR: begin
                ctrl_o.ALUBsrc     = 1'b1;
                ctrl_o.Immsrc      = IMM_I;
                ctrl_o.BUOp        = BU_JUMP;
                ctrl_o.RuDataWrsrc = WB_PC4;
                ctrl_o.RuWr        = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle RV32I sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB, with
// variable-latency instruction/data memory handshakes, a sticky TRAP state for
// illegal instructions, and free-running cycle / retired-instruction counters.
//   clk, rst_n                    clock (rising edge), async active-low reset
//   instr, imem_req, imem_ready   instruction fetch handshake
//   dmem_req, dmem_ready, DmWr    data access handshake and write enable
//   ir_wr, pc_wr, RuWr            IR load, PC update, register write strobes
//   ALUOp ... RuDataWrsrc, DmCtrl registered control word for the datapath
//   trap                          illegal instruction seen (held until reset)
//   cycle_cnt, instret_cnt        CNT_W-bit counters, wrap silently
// -----------------------------------------------------------------------------
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             dmem_req,
    input  logic             dmem_ready,
    output logic             DmWr,
    output logic [2:0]       DmCtrl,
    output logic             ir_wr,
    output logic             pc_wr,
    output logic             RuWr,
    output logic [3:0]       ALUOp,
    output logic             ALUAsrc,
    output logic             ALUBsrc,
    output logic [2:0]       Immsrc,
    output logic [4:0]       BUOp,
    output logic [1:0]       RuDataWrsrc,
    output logic             trap,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    ctrl_word_t       ctrl_q, ctrl_d;
    ctrl_word_t       dec_ctrl;
    logic             dec_illegal;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] cycle_q, instret_q;
    logic             is_mem_op;

    ctrl_decoder u_decoder (
        .instr_i   (ir_q),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal)
    );

    // Only loads write back from memory and only stores write it, so the
    // registered control word alone tells EXEC whether a MEM phase is needed.
    assign is_mem_op = ctrl_q.DmWr || (ctrl_q.RuDataWrsrc == WB_MEM);

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        ir_d     = ir_q;
        imem_req = 1'b0;
        ir_wr    = 1'b0;
        dmem_req = 1'b0;
        DmWr     = 1'b0;
        pc_wr    = 1'b0;
        RuWr     = 1'b0;
        trap     = 1'b0;

        // Strobes and requests are qualified by rst_n so an in-flight request
        // drops in the same cycle reset asserts, not at the next edge.
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_wr   = 1'b1;
                        ir_d    = instr;
                        state_d = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (dec_illegal) begin
                        state_d = ST_TRAP;
                    end else begin
                        ctrl_d  = dec_ctrl;
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: state_d = is_mem_op ? ST_MEM : ST_WB;
                ST_MEM: begin
                    dmem_req = 1'b1;
                    DmWr     = ctrl_q.DmWr;
                    if (dmem_ready) state_d = ST_WB;
                end
                ST_WB: begin
                    pc_wr   = 1'b1;
                    RuWr    = ctrl_q.RuWr;
                    state_d = ST_FETCH;
                end
                ST_TRAP: trap = 1'b1;
                default: state_d = ST_FETCH;
            endcase
        end
    end

    // NOTE: the IR and control word are small registers, not memories, so
    // they are reset to keep the datapath free of X after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            ctrl_q    <= '0;
            ir_q      <= '0;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            ir_q    <= ir_d;
            cycle_q <= cycle_q + CNT_ONE;
            if (state_q == ST_WB) instret_q <= instret_q + CNT_ONE;
        end
    end

    assign ALUOp       = ctrl_q.ALUOp;
    assign ALUAsrc     = ctrl_q.ALUAsrc;
    assign ALUBsrc     = ctrl_q.ALUBsrc;
    assign Immsrc      = ctrl_q.Immsrc;
    assign BUOp        = ctrl_q.BUOp;
    assign DmCtrl      = ctrl_q.DmCtrl;
    assign RuDataWrsrc = ctrl_q.RuDataWrsrc;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Builds a cycle-by-cycle expectation table from a list of directed
// instructions (per-instruction fetch/data wait states, optional trap length,
// optional reset in the middle of MEM). Inputs are driven 1 ns after each
// rising edge; outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      instr;
    logic             imem_req, imem_ready;
    logic             dmem_req, dmem_ready;
    logic             DmWr;
    logic [2:0]       DmCtrl;
    logic             ir_wr, pc_wr, RuWr;
    logic [3:0]       ALUOp;
    logic             ALUAsrc, ALUBsrc;
    logic [2:0]       Immsrc;
    logic [4:0]       BUOp;
    logic [1:0]       RuDataWrsrc;
    logic             trap;
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .imem_req    (imem_req),
        .imem_ready  (imem_ready),
        .dmem_req    (dmem_req),
        .dmem_ready  (dmem_ready),
        .DmWr        (DmWr),
        .DmCtrl      (DmCtrl),
        .ir_wr       (ir_wr),
        .pc_wr       (pc_wr),
        .RuWr        (RuWr),
        .ALUOp       (ALUOp),
        .ALUAsrc     (ALUAsrc),
        .ALUBsrc     (ALUBsrc),
        .Immsrc      (Immsrc),
        .BUOp        (BUOp),
        .RuDataWrsrc (RuDataWrsrc),
        .trap        (trap),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       a_src;
        logic       b_src;
        logic [2:0] imm;
        logic [4:0] bu_op;
        logic       dm_wr;
        logic [2:0] dm_ctrl;
        logic [1:0] wb_src;
        logic       ru_wr;
    } exp_ctrl_t;

    typedef enum {PIN_NONE, PIN_ALUOP, PIN_BUOP, PIN_IMM, PIN_DMCTRL, PIN_WBSRC,
                  PIN_DMWR, PIN_CYCLE, PIN_INSTRET, PIN_TRAP, PIN_RUWR} pin_e;
    typedef enum {STG_NONE, STG_FETCH, STG_EXEC, STG_MEM, STG_WB, STG_TRAP} stage_e;

    typedef struct {
        logic        rst_n;
        logic [31:0] instr;
        logic        imem_ready;
        logic        dmem_ready;
        logic        imem_req;
        logic        ir_wr;
        logic        dmem_req;
        logic        dm_wr;
        logic        pc_wr;
        logic        ru_wr;
        logic        trap;
        logic        chk_ctrl;
        exp_ctrl_t   ctrl;
        logic [31:0] cyc;
        logic [31:0] instret;
        pin_e        pin_sel;
        logic [31:0] pin_val;
    } cyc_t;

    cyc_t        sched[$];
    logic [31:0] m_cyc;
    logic [31:0] m_instret;
    exp_ctrl_t   m_ctrl;
    bit          m_ctrl_ok;

    int n_checks = 0;
    int n_fail   = 0;
    int cur      = 0;
    bit active   = 1'b0;

    // ---------------- model ----------------
    function automatic logic [3:0] alu_of(input logic [2:0] f3);
        if (f3 == 3'd2) return 4'b0011;
        if (f3 == 3'd3) return 4'b0010;
        return {1'b0, f3};
    endfunction

    function automatic void model_decode(input logic [31:0] ins, output exp_ctrl_t c,
                                         output bit bad, output bit mem);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op  = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        c   = '0;
        bad = 1'b0;
        mem = 1'b0;
        if (op == 7'h33) begin
            c.ru_wr = 1'b1;
            if (f7 == 7'h00)                   c.alu_op = alu_of(f3);
            else if (f7 == 7'h20 && f3 == 3'd0) c.alu_op = 4'b1000;
            else if (f7 == 7'h20 && f3 == 3'd5) c.alu_op = 4'b1101;
            else                               bad = 1'b1;
        end else if (op == 7'h13) begin
            c.alu_op = alu_of(f3); c.b_src = 1'b1; c.ru_wr = 1'b1;
        end else if (op == 7'h03) begin
            c.b_src = 1'b1; c.wb_src = 2'b01; c.dm_ctrl = f3; c.ru_wr = 1'b1; mem = 1'b1;
        end else if (op == 7'h23) begin
            c.b_src = 1'b1; c.imm = 3'b001; c.dm_wr = 1'b1; c.dm_ctrl = f3; mem = 1'b1;
        end else if (op == 7'h63) begin
            bad = (f3 == 3'd2) || (f3 == 3'd3);
            c.a_src = 1'b1; c.b_src = 1'b1; c.imm = 3'b101; c.bu_op = {2'b01, f3};
        end else if (op == 7'h6F) begin
            c.a_src = 1'b1; c.b_src = 1'b1; c.imm = 3'b110; c.bu_op = 5'b10000;
            c.wb_src = 2'b10; c.ru_wr = 1'b1;
        end else if (op == 7'h67) begin
            c.b_src = 1'b1; c.bu_op = 5'b10000; c.wb_src = 2'b10; c.ru_wr = 1'b1;
        end else begin
            bad = 1'b1;
        end
    endfunction

    function automatic cyc_t blank();
        cyc_t e;
        e.rst_n      = 1'b1;
        e.instr      = 32'hDEAD_BEEF;
        e.imem_ready = 1'b1;   // spurious readies must be ignored
        e.dmem_ready = 1'b1;
        e.imem_req   = 1'b0;
        e.ir_wr      = 1'b0;
        e.dmem_req   = 1'b0;
        e.dm_wr      = 1'b0;
        e.pc_wr      = 1'b0;
        e.ru_wr      = 1'b0;
        e.trap       = 1'b0;
        e.chk_ctrl   = 1'b0;
        e.ctrl       = '0;
        e.cyc        = '0;
        e.instret    = '0;
        e.pin_sel    = PIN_NONE;
        e.pin_val    = '0;
        return e;
    endfunction

    task automatic push(input cyc_t e);
        if (!e.rst_n) begin
            m_cyc = '0; m_instret = '0; m_ctrl = '0; m_ctrl_ok = 1'b1;
        end
        e.cyc      = m_cyc;
        e.instret  = m_instret;
        e.ctrl     = m_ctrl;
        e.chk_ctrl = m_ctrl_ok;
        sched.push_back(e);
        if (e.rst_n) m_cyc = m_cyc + 32'd1;
    endtask

    task automatic add_reset(input int n);
        cyc_t e;
        for (int k = 0; k < n; k++) begin
            e = blank();
            e.rst_n = 1'b0; e.instr = '0; e.imem_ready = 1'b0; e.dmem_ready = 1'b0;
            push(e);
        end
    endtask

    task automatic add_instr(input logic [31:0] ins, input int iw, input int dw,
                             input int trap_n, input int rst_mem,
                             input stage_e pin_stage, input pin_e pin_sel,
                             input logic [31:0] pin_val);
        exp_ctrl_t c;
        bit        bad, mem;
        cyc_t      e;
        model_decode(ins, c, bad, mem);
        for (int k = 0; k <= iw; k++) begin
            e = blank();
            e.imem_req = 1'b1;
            if (k == iw) begin
                e.imem_ready = 1'b1; e.instr = ins; e.ir_wr = 1'b1;
            end else begin
                e.imem_ready = 1'b0;
            end
            if (pin_stage == STG_FETCH && k == 0) begin e.pin_sel = pin_sel; e.pin_val = pin_val; end
            push(e);
        end
        e = blank();
        push(e);   // DECODE
        if (bad) begin
            m_ctrl_ok = 1'b0;
            for (int k = 0; k < trap_n; k++) begin
                e = blank();
                e.trap = 1'b1;
                if (pin_stage == STG_TRAP && k == 0) begin e.pin_sel = pin_sel; e.pin_val = pin_val; end
                push(e);
            end
            return;
        end
        m_ctrl = c;
        e = blank();
        if (pin_stage == STG_EXEC) begin e.pin_sel = pin_sel; e.pin_val = pin_val; end
        push(e);   // EXEC
        if (mem) begin
            for (int k = 0; k <= dw; k++) begin
                if (k == rst_mem) begin
                    add_reset(2);
                    return;
                end
                e = blank();
                e.dmem_req   = 1'b1;
                e.dm_wr      = c.dm_wr;
                e.dmem_ready = (k == dw);
                e.imem_ready = 1'b1;
                if (pin_stage == STG_MEM && k == 0) begin e.pin_sel = pin_sel; e.pin_val = pin_val; end
                push(e);
            end
        end
        e = blank();
        e.pc_wr = 1'b1;
        e.ru_wr = c.ru_wr;
        if (pin_stage == STG_WB) begin e.pin_sel = pin_sel; e.pin_val = pin_val; end
        push(e);   // WB
        m_instret = m_instret + 32'd1;
    endtask

    task automatic build_schedule();
        m_cyc = '0; m_instret = '0; m_ctrl = '0; m_ctrl_ok = 1'b1;
        add_reset(2);
        add_instr(32'h002081B3, 0, 0, 0, -1, STG_EXEC,  PIN_ALUOP,   32'h0);   // add
        add_instr(32'h0080A283, 0, 3, 0, -1, STG_MEM,   PIN_DMCTRL,  32'h2);   // lw
        add_instr(32'h0050A423, 2, 1, 0, -1, STG_FETCH, PIN_CYCLE,   32'd12);  // sw
        add_instr(32'h00508023, 0, 0, 0, -1, STG_MEM,   PIN_DMWR,    32'h1);   // sb
        add_instr(32'h402081B3, 0, 0, 0, -1, STG_EXEC,  PIN_ALUOP,   32'h8);   // sub
        add_instr(32'h00208463, 1, 0, 0, -1, STG_EXEC,  PIN_BUOP,    32'h08);  // beq
        add_instr(32'h0020D463, 0, 0, 0, -1, STG_EXEC,  PIN_IMM,     32'h5);   // bge
        add_instr(32'hFFF10093, 0, 0, 0, -1, STG_FETCH, PIN_INSTRET, 32'd7);   // addi
        add_instr(32'h4030D093, 0, 0, 0, -1, STG_EXEC,  PIN_ALUOP,   32'h5);   // srai
        add_instr(32'h008000EF, 0, 0, 0, -1, STG_EXEC,  PIN_BUOP,    32'h10);  // jal
        add_instr(32'h00008067, 0, 0, 0, -1, STG_EXEC,  PIN_WBSRC,   32'h2);   // jalr
        add_instr(32'h0000C103, 1, 2, 0, -1, STG_MEM,   PIN_DMCTRL,  32'h4);   // lbu
        add_instr(32'h4020D1B3, 0, 0, 0, -1, STG_EXEC,  PIN_ALUOP,   32'hD);   // sra
        add_instr(32'h0020B1B3, 0, 0, 0, -1, STG_EXEC,  PIN_ALUOP,   32'h2);   // sltu
        add_instr(32'h0020A093, 0, 0, 0, -1, STG_EXEC,  PIN_ALUOP,   32'h3);   // slti
        add_instr(32'h0050A423, 0, 5, 0,  2, STG_NONE,  PIN_NONE,    32'h0);   // sw, reset in MEM
        add_instr(32'h002081B3, 0, 0, 0, -1, STG_FETCH, PIN_CYCLE,   32'd0);   // add after reset
        add_instr(32'hFE2081B3, 0, 0, 5, -1, STG_TRAP,  PIN_TRAP,    32'h1);   // bad func7
        add_reset(2);
        add_instr(32'hFFFFFFFF, 0, 0, 20, -1, STG_TRAP, PIN_TRAP,    32'h1);
        add_reset(1);
        add_instr(32'h0020A463, 0, 0, 4, -1, STG_NONE,  PIN_NONE,    32'h0);   // branch f3=010
        add_reset(1);
        add_instr(32'h000000B7, 0, 0, 3, -1, STG_NONE,  PIN_NONE,    32'h0);   // lui: unsupported
        add_reset(1);
        add_instr(32'h002081B3, 0, 0, 0, -1, STG_WB,    PIN_RUWR,    32'h1);
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (table row %0d, t=%0t)", name, act, exp, cur, $time);
        end
    endtask

    cyc_t ce;
    always @(negedge clk) begin
        if (active) begin
            ce = sched[cur];
            check("imem_req",    32'(imem_req),    32'(ce.imem_req));
            check("ir_wr",       32'(ir_wr),       32'(ce.ir_wr));
            check("dmem_req",    32'(dmem_req),    32'(ce.dmem_req));
            check("pc_wr",       32'(pc_wr),       32'(ce.pc_wr));
            check("RuWr",        32'(RuWr),        32'(ce.ru_wr));
            check("trap",        32'(trap),        32'(ce.trap));
            check("cycle_cnt",   32'(cycle_cnt),   ce.cyc);
            check("instret_cnt", 32'(instret_cnt), ce.instret);
            if (ce.dmem_req) check("DmWr", 32'(DmWr), 32'(ce.dm_wr));
            if (ce.chk_ctrl) begin
                check("ALUOp",       32'(ALUOp),       32'(ce.ctrl.alu_op));
                check("ALUAsrc",     32'(ALUAsrc),     32'(ce.ctrl.a_src));
                check("ALUBsrc",     32'(ALUBsrc),     32'(ce.ctrl.b_src));
                check("Immsrc",      32'(Immsrc),      32'(ce.ctrl.imm));
                check("BUOp",        32'(BUOp),        32'(ce.ctrl.bu_op));
                check("DmCtrl",      32'(DmCtrl),      32'(ce.ctrl.dm_ctrl));
                check("RuDataWrsrc", 32'(RuDataWrsrc), 32'(ce.ctrl.wb_src));
            end
            case (ce.pin_sel)
                PIN_ALUOP:   check("pin ALUOp",       32'(ALUOp),       ce.pin_val);
                PIN_BUOP:    check("pin BUOp",        32'(BUOp),        ce.pin_val);
                PIN_IMM:     check("pin Immsrc",      32'(Immsrc),      ce.pin_val);
                PIN_DMCTRL:  check("pin DmCtrl",      32'(DmCtrl),      ce.pin_val);
                PIN_WBSRC:   check("pin RuDataWrsrc", 32'(RuDataWrsrc), ce.pin_val);
                PIN_DMWR:    check("pin DmWr",        32'(DmWr),        ce.pin_val);
                PIN_CYCLE:   check("pin cycle_cnt",   32'(cycle_cnt),   ce.pin_val);
                PIN_INSTRET: check("pin instret_cnt", 32'(instret_cnt), ce.pin_val);
                PIN_TRAP:    check("pin trap",        32'(trap),        ce.pin_val);
                PIN_RUWR:    check("pin RuWr",        32'(RuWr),        ce.pin_val);
                default: ;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n      = 1'b0;
        instr      = '0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        build_schedule();
        for (int i = 0; i < sched.size(); i++) begin
            @(posedge clk);
            #1;
            rst_n      = sched[i].rst_n;
            instr      = sched[i].instr;
            imem_ready = sched[i].imem_ready;
            dmem_ready = sched[i].dmem_ready;
            cur        = i;
            active     = 1'b1;
        end
        @(posedge clk);
        #1;
        active = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
